branch_unit: RTL
================

# branch_unit

Parametrised branch/jump resolution unit for the execute stage. It holds the condition flags in registers, resolves conditional branches, jumps, calls and returns, and keeps return addresses in a small circular return-address stack (RAS). It drives the fetch redirect (`next_pc`, `take_branch`) and a one-cycle `flush` that squashes the wrong-path instruction behind any taken redirect.

## Interface
Parameters:
- `PC_W`, 10, program counter width in bits
- `RAS_DEPTH`, 4, number of RAS entries; power of two, at least 2

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  pipeline advance; when 0, no architectural state changes and `flush` holds its value
- `pc_plus_1`  in  PC_W  fall-through address
- `target`  in  PC_W  ALU-computed branch, jump or call target
- `flag_we`  in  1  capture the ALU flags this cycle
- `alu_zero`, `alu_positive`  in  1 each  flags from the current ALU result
- `branch_op`, `jump_op`, `call_op`, `ret_op`  in  1 each  decoded operation
- `branch_cond`  in  2  `branch_cond_e`: 00 ZERO, 01 POS, 10 NEG, 11 ALWAYS
- `next_pc`  out  PC_W  redirect address
- `take_branch`  out  1  redirect fetch this cycle (combinational)
- `flush`  out  1  squash the instruction currently in execute
- `zero_flag`, `positive_flag`  out  1 each  registered flags
- `ras_overflow`, `ras_underflow`  out  1 each  sticky error flags

## Operation
- **Flags.** On `en & flag_we & ~flush`, capture `zero_flag <= alu_zero` and `positive_flag <= alu_positive`.
- **Branch condition.** Evaluated against the registered flags, never the same-cycle ALU flags.
  - ZERO: `zero_flag`
  - POS: `positive_flag`
  - NEG: `~zero_flag & ~positive_flag`
  - ALWAYS: 1
- **Priority.** `ret_op` > `call_op` > `jump_op` > `branch_op`. Lower-priority ops asserted in the same cycle are ignored.
- **Effective cycle.** `en & ~flush`. Outside an effective cycle, `take_branch` = 0 and no push or pop occurs.
- **jump_op.** `take_branch` = 1, `next_pc` = `target`.
- **branch_op.** `take_branch` = condition; `next_pc` = `target` if taken, else `pc_plus_1`.
- **call_op.** `take_branch` = 1, `next_pc` = `target`; push `pc_plus_1` onto the RAS.
- **ret_op, RAS non-empty.** `take_branch` = 1, `next_pc` = top entry; pop.
- **ret_op, RAS empty.** `take_branch` = 0, `next_pc` = `pc_plus_1`; set `ras_underflow`.
- **No operation.** `take_branch` = 0, `next_pc` = `pc_plus_1`.
- **RAS structure.** Circular buffer with top pointer `clog2(RAS_DEPTH)` bits wide and count `0..RAS_DEPTH`.
- **Push when full.** Overwrites the oldest entry; the pointer wraps and count stays at `RAS_DEPTH`. Set `ras_overflow`.
- **Sticky flags.** `ras_overflow` and `ras_underflow` clear only on `rst`.
- **Flush.** When `en`: `flush <= take_branch`. When `~en`: `flush` holds.
- **Squashed instruction.** While `flush` = 1, the instruction in execute has no effect: no flag write, no push or pop, no redirect.

## Timing
- `next_pc` and `take_branch` are combinational from the inputs and the registered state: zero-cycle redirect.
- Flags, RAS contents, RAS count and `flush` update on the rising edge of `clk`.
- A flag written in cycle N is first visible to a branch in cycle N+1.
- A flag write and a branch in the same cycle: the branch uses the old flags.
- A call in cycle N and a ret in cycle N+1: the ret is squashed by `flush`. The earliest effective ret is in cycle N+2, and it returns the pushed value.
- Reset values: `zero_flag`=0, `positive_flag`=0, RAS count=0, top pointer=0, `flush`=0, `ras_overflow`=0, `ras_underflow`=0. RAS data is don't-care.
- `rst` has priority over `en`.
- Reset asserted mid-sequence: state returns to reset values on the next edge, and pending pushes or pops are discarded.
- A stall (`en`=0) with `flush`=1 keeps the squash pending until the next enabled cycle.

## Structure
- Package `common_def`:
  - `branch_cond_e` enum
  - `PC_W_DEFAULT` = 10
  - `RAS_DEPTH_DEFAULT` = 4
- Sub-module `return_addr_stack`:
  - parameters `PC_W`, `RAS_DEPTH`
  - ports: `push`, `pop`, `push_data`, `top_data`, `empty`, `full`
  - owns the pointer, count and storage
  - `push` and `pop` are mutually exclusive by construction
- The `branch_unit` top level contains the flag registers, priority and condition logic, and the flush register.

## Test plan
- Reset, then idle with `pc_plus_1`=0x005 → `next_pc`=0x005, `take_branch`=0, `flush`=0, flags 0.
- Cycle N: `flag_we`, `alu_zero`=1. Cycle N+1: branch ZERO to 0x040 → taken, `next_pc`=0x040, `flush`=1 in N+2. The same branch issued in cycle N itself is not taken.
- Branch NEG with `zero_flag`=0 and `positive_flag`=0 → taken. Branch POS with `positive_flag`=1 while `flush`=1 → `take_branch`=0, flags unchanged.
- Call at `pc_plus_1`=0x011 to 0x100, idle, then ret → `next_pc`=0x011, `take_branch`=1. A ret directly after the call is squashed.
- `RAS_DEPTH`=4: five calls (separated by idles) with returns 0x001..0x005, then five rets → rets yield 0x005, 0x004, 0x003, 0x002, then underflow (`take_branch`=0); `ras_overflow`=1 and `ras_underflow`=1, both sticky.
- `call_op`, `jump_op` and `ret_op` together with RAS empty → ret wins, `take_branch`=0, no push, `ras_underflow`=1. `en`=0 with `flush`=1 → `flush` held.

Source files
------------

// File: rtl/common_def.sv
`default_nettype none
// ============================================================================
// Module   : common_def (package)
// Purpose  : Shared types and default sizes for the branch resolution unit.
// Revision : 1.0 - initial release
// ============================================================================
package common_def;

    typedef enum logic [1:0] {
        COND_ZERO   = 2'b00,
        COND_POS    = 2'b01,
        COND_NEG    = 2'b10,
        COND_ALWAYS = 2'b11
    } branch_cond_e;

    localparam int PC_W_DEFAULT      = 10;
    localparam int RAS_DEPTH_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module   : return_addr_stack
// Purpose  : Circular return-address stack; a push when full drops the oldest.
// Revision : 1.0 - initial release
// ============================================================================
module return_addr_stack #(
    parameter int PC_W      = 10,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top_data,
    output logic            empty,
    output logic            full
);

    localparam int c_ptr_w = $clog2(RAS_DEPTH);
    localparam int c_cnt_w = $clog2(RAS_DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(RAS_DEPTH);

    logic [PC_W-1:0]    r_mem [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_top;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] w_top_idx;

    // r_top is the next write slot; the newest entry sits one below it.
    assign w_top_idx = r_top - c_ptr_one;
    assign top_data  = r_mem[w_top_idx];
    assign empty     = (r_count == '0);
    assign full      = (r_count == c_depth);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_top <= r_top + c_ptr_one;
            if (!full) begin
                r_count <= r_count + c_cnt_one;
            end
        end else if (pop) begin
            r_top   <= w_top_idx;
            r_count <= r_count - c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            r_mem[r_top] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit
// Purpose  : Execute-stage branch/jump/call/return resolution with flush.
// Revision : 1.0 - initial release
// ============================================================================
module branch_unit
    import common_def::*;
#(
    parameter int PC_W      = PC_W_DEFAULT,
    parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [PC_W-1:0] pc_plus_1,
    input  logic [PC_W-1:0] target,
    input  logic            flag_we,
    input  logic            alu_zero,
    input  logic            alu_positive,
    input  logic            branch_op,
    input  logic            jump_op,
    input  logic            call_op,
    input  logic            ret_op,
    input  logic [1:0]      branch_cond,
    output logic [PC_W-1:0] next_pc,
    output logic            take_branch,
    output logic            flush,
    output logic            zero_flag,
    output logic            positive_flag,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    logic            r_zero_flag;
    logic            r_positive_flag;
    logic            r_flush;
    logic            r_ras_overflow;
    logic            r_ras_underflow;

    logic            w_effective;
    logic            w_cond;
    logic            w_take;
    logic [PC_W-1:0] w_next_pc;
    logic            w_push;
    logic            w_pop;
    logic            w_overflow_evt;
    logic            w_underflow_evt;
    logic [PC_W-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_ras_full;

    // The instruction behind a taken redirect is wrong-path and must be inert.
    assign w_effective = en & ~r_flush;

    always_comb begin
        w_cond = 1'b0;
        unique case (branch_cond_e'(branch_cond))
            COND_ZERO:   w_cond = r_zero_flag;
            COND_POS:    w_cond = r_positive_flag;
            COND_NEG:    w_cond = ~r_zero_flag & ~r_positive_flag;
            COND_ALWAYS: w_cond = 1'b1;
        endcase
    end

    always_comb begin
        w_take          = 1'b0;
        w_next_pc       = pc_plus_1;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_overflow_evt  = 1'b0;
        w_underflow_evt = 1'b0;
        if (w_effective) begin
            if (ret_op) begin
                if (!w_ras_empty) begin
                    w_take    = 1'b1;
                    w_next_pc = w_ras_top;
                    w_pop     = 1'b1;
                end else begin
                    w_underflow_evt = 1'b1;
                end
            end else if (call_op) begin
                w_take         = 1'b1;
                w_next_pc      = target;
                w_push         = 1'b1;
                w_overflow_evt = w_ras_full;
            end else if (jump_op) begin
                w_take    = 1'b1;
                w_next_pc = target;
            end else if (branch_op && w_cond) begin
                w_take    = 1'b1;
                w_next_pc = target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero_flag     <= 1'b0;
            r_positive_flag <= 1'b0;
            r_flush         <= 1'b0;
            r_ras_overflow  <= 1'b0;
            r_ras_underflow <= 1'b0;
        end else begin
            if (w_effective && flag_we) begin
                r_zero_flag     <= alu_zero;
                r_positive_flag <= alu_positive;
            end
            if (en) begin
                r_flush <= w_take;
            end
            r_ras_overflow  <= r_ras_overflow  | w_overflow_evt;
            r_ras_underflow <= r_ras_underflow | w_underflow_evt;
        end
    end

    return_addr_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (pc_plus_1),
        .top_data  (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full)
    );

    assign next_pc       = w_next_pc;
    assign take_branch   = w_take;
    assign flush         = r_flush;
    assign zero_flag     = r_zero_flag;
    assign positive_flag = r_positive_flag;
    assign ras_overflow  = r_ras_overflow;
    assign ras_underflow = r_ras_underflow;

endmodule
`default_nettype wire
